// File: rtl/reduce_gate_acc_if.sv
// reduce_gate_acc_if: beat stream in, one registered verdict per frame out
interface reduce_gate_acc_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_data;
    logic [CNT_W-1:0] out_beats;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_data, in_last, op,
        input  out_valid, out_data, out_beats, out_err, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, op,
        output out_valid, out_data, out_beats, out_err, busy
    );
endinterface

// File: rtl/reduce_gate_acc.sv
// reduce_gate_acc: pipelined AND/OR/XOR (optionally inverted) reduction accumulated over multi-beat frames
module reduce_gate_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    reduce_gate_acc_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OPEN = 1'b1;

    logic [0:0]       state;
    logic [2:0]       op_q;
    logic [2:0]       op_e;
    logic [WIDTH-1:0] d;
    logic [1:0]       base_e;
    logic [1:0]       base_1;
    logic             r_beat;
    logic             s1_valid, s1_r, s1_first, s1_last;
    logic [2:0]       s1_op;
    logic             acc, acc_next;
    logic [CNT_W-1:0] cnt;
    logic             s2_done;
    logic [2:0]       s2_op;
    logic             inv, rsv;

    // 0 = AND, 1 = OR, 2 = XOR; reserved ops fall into XOR but are masked at the output
    function automatic logic [1:0] base_of(input logic [2:0] o);
        return (o == 3'd0 || o == 3'd3) ? 2'd0 : (o == 3'd1 || o == 3'd4) ? 2'd1 : 2'd2;
    endfunction

    assign d       = bus.in_data;
    assign op_e    = (state == IDLE) ? bus.op : op_q;
    assign base_e  = base_of(op_e);
    assign base_1  = base_of(s1_op);
    assign r_beat  = base_e == 2'd0 ? &d : base_e == 2'd1 ? |d : ^d;
    assign acc_next = base_1 == 2'd0 ? (acc & s1_r) : base_1 == 2'd1 ? (acc | s1_r) : (acc ^ s1_r);
    assign inv     = s2_op == 3'd3 || s2_op == 3'd4 || s2_op == 3'd5;
    assign rsv     = s2_op[2] & s2_op[1];
    assign bus.busy = state == OPEN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_q          <= '0;
            s1_valid      <= 1'b0;
            s1_r          <= 1'b0;
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
            s1_op         <= '0;
            acc           <= 1'b0;
            cnt           <= '0;
            s2_done       <= 1'b0;
            s2_op         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 1'b0;
            bus.out_beats <= '0;
            bus.out_err   <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                state <= bus.in_last ? IDLE : OPEN;
                op_q  <= op_e;
            end
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_r     <= r_beat;
                s1_first <= state == IDLE;
                s1_last  <= bus.in_last;
                s1_op    <= op_e;
            end
            s2_done <= s1_valid & s1_last;
            if (s1_valid) begin
                acc   <= s1_first ? s1_r : acc_next;
                cnt   <= s1_first ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
                s2_op <= s1_op;
            end
            bus.out_valid <= s2_done;
            if (s2_done) begin
                bus.out_data  <= rsv ? 1'b0 : acc ^ inv;
                bus.out_beats <= cnt;
                bus.out_err   <= rsv;
            end
        end
    end
endmodule

// File: tb/tb_reduce_gate_acc.sv
// tb_reduce_gate_acc: directed frames into an 8-bit and a 4-bit/2-bit-counter instance, scoreboard-checked
module tb_reduce_gate_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct packed {
        logic       d;
        logic [7:0] b;
        logic       e;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    reduce_gate_acc_if #(.WIDTH(8), .CNT_W(8)) a ();
    reduce_gate_acc_if #(.WIDTH(4), .CNT_W(2)) b ();

    reduce_gate_acc #(.WIDTH(8), .CNT_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
    reduce_gate_acc #(.WIDTH(4), .CNT_W(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sa(input logic [7:0] d, input logic l, input logic [2:0] o);
        @(negedge clk);
        a.in_valid = 1'b1; a.in_data = d; a.in_last = l; a.op = o;
        b.in_valid = 1'b0;
    endtask

    task automatic sb(input logic [3:0] d, input logic l, input logic [2:0] o);
        @(negedge clk);
        b.in_valid = 1'b1; b.in_data = d; b.in_last = l; b.op = o;
        a.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a.in_valid = 1'b0;
            b.in_valid = 1'b0;
        end
    endtask

    task automatic ea(input logic d, input logic [7:0] n, input logic e);
        qa.push_back('{d: d, b: n, e: e});
    endtask

    task automatic eb(input logic d, input logic [7:0] n, input logic e);
        qb.push_back('{d: d, b: n, e: e});
    endtask

    initial begin
        a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.op = '0;
        b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.op = '0;
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (a.out_valid) begin
                    if (qa.size() == 0) chk("a_spurious_valid", {31'd0, a.out_valid}, 32'd0);
                    else begin
                        e = qa.pop_front();
                        chk("a_out_data", {31'd0, a.out_data}, {31'd0, e.d});
                        chk("a_out_beats", {24'd0, a.out_beats}, {24'd0, e.b});
                        chk("a_out_err", {31'd0, a.out_err}, {31'd0, e.e});
                    end
                end
                if (b.out_valid) begin
                    if (qb.size() == 0) chk("b_spurious_valid", {31'd0, b.out_valid}, 32'd0);
                    else begin
                        e = qb.pop_front();
                        chk("b_out_data", {31'd0, b.out_data}, {31'd0, e.d});
                        chk("b_out_beats", {30'd0, b.out_beats}, {24'd0, e.b});
                        chk("b_out_err", {31'd0, b.out_err}, {31'd0, e.e});
                    end
                end
            end
            begin
                idle(3);
                chk("rst_a_out_valid", {31'd0, a.out_valid}, 32'd0);
                chk("rst_a_out_data", {31'd0, a.out_data}, 32'd0);
                chk("rst_a_out_beats", {24'd0, a.out_beats}, 32'd0);
                chk("rst_a_out_err", {31'd0, a.out_err}, 32'd0);
                chk("rst_a_busy", {31'd0, a.busy}, 32'd0);
                chk("rst_b_out_valid", {31'd0, b.out_valid}, 32'd0);
                chk("rst_b_busy", {31'd0, b.busy}, 32'd0);
                @(negedge clk) rst_n = 1'b1;
                idle(1);
                // 4-bit NOR single beats
                eb(1'b1, 8'd1, 1'b0); sb(4'b0000, 1'b1, 3'd4);
                eb(1'b0, 8'd1, 1'b0); sb(4'b0100, 1'b1, 3'd4);
                idle(4);
                // XOR frame with a gap, busy tracking
                sa(8'h01, 1'b0, 3'd2);
                sa(8'h03, 1'b0, 3'd2);
                chk("xor_busy_after_b1", {31'd0, a.busy}, 32'd1);
                idle(1);
                chk("xor_busy_gap", {31'd0, a.busy}, 32'd1);
                ea(1'b1, 8'd3, 1'b0); sa(8'h00, 1'b1, 3'd2);
                idle(1);
                chk("xor_busy_after_last", {31'd0, a.busy}, 32'd0);
                idle(3);
                // op latched on first beat
                sa(8'hFF, 1'b0, 3'd0);
                ea(1'b1, 8'd2, 1'b0); sa(8'hFF, 1'b1, 3'd1);
                sa(8'hFF, 1'b0, 3'd0);
                ea(1'b0, 8'd2, 1'b0); sa(8'hFE, 1'b1, 3'd0);
                sa(8'h00, 1'b0, 3'd1);
                ea(1'b1, 8'd2, 1'b0); sa(8'h01, 1'b1, 3'd0);
                idle(4);
                // back-to-back single-beat frames with differing ops
                ea(1'b0, 8'd1, 1'b0); sa(8'hFF, 1'b1, 3'd3);
                ea(1'b1, 8'd1, 1'b0); sa(8'h00, 1'b1, 3'd5);
                ea(1'b0, 8'd1, 1'b0); sa(8'h00, 1'b1, 3'd1);
                idle(4);
                // counter saturation at 3 and reserved op
                sb(4'h0, 1'b0, 3'd1);
                sb(4'h0, 1'b0, 3'd1);
                sb(4'h1, 1'b0, 3'd1);
                sb(4'h0, 1'b0, 3'd1);
                eb(1'b1, 8'd3, 1'b0); sb(4'h0, 1'b1, 3'd1);
                eb(1'b0, 8'd1, 1'b1); sb(4'hF, 1'b1, 3'd7);
                idle(5);
                // reset in the middle of a frame
                sa(8'hFF, 1'b0, 3'd1);
                sa(8'hFF, 1'b0, 3'd1);
                chk("abort_busy_pre", {31'd0, a.busy}, 32'd1);
                rst_n = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    idle(1);
                    chk("abort_busy", {31'd0, a.busy}, 32'd0);
                    chk("abort_out_valid", {31'd0, a.out_valid}, 32'd0);
                end
                @(negedge clk) rst_n = 1'b1;
                ea(1'b1, 8'd1, 1'b0); sa(8'h80, 1'b1, 3'd1);
                idle(6);
            end
        join_any
        disable fork;
        chk("a_pending_results", qa.size(), 32'd0);
        chk("b_pending_results", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
